sseg_scan: RTL and testbench

SSEG_SCAN -- requirements
Module: sseg_scan

---
 rtl/sseg_pkg.sv | 15 +
 rtl/sseg_scan_hex_to_sseg.sv | 14 +
 rtl/sseg_scan.sv | 104 ++++++++++
 tb/tb_sseg_scan.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared constants for the six-digit multiplexed seven-segment scanner.
package sseg_pkg;

    localparam int unsigned NUM_DIGITS = 6;

    // Fully dark pattern for segments plus decimal point (active low).
    localparam logic [7:0] SSEG_BLANK = 8'hFF;

    // Active-low glyphs, bit0=a .. bit6=g, indexed by nibble value 0..F.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/sseg_scan_hex_to_sseg.sv
// Combinational nibble to active-low seven-segment glyph decoder.
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Table lookup of the glyph for the selected nibble.
    always_comb begin
        o_seg = GLYPH_TABLE[i_nibble];
    end

endmodule

// File: rtl/sseg_scan.sv
// Six-digit multiplexed seven-segment scanner with per-slot ghosting guard,
// frame-synchronous input snapshot and optional leading-zero blanking.
module sseg_scan
    import sseg_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] value,
    input  logic [5:0]  dp,
    input  logic        blank_lz,
    output logic [7:0]  sseg,
    output logic [5:0]  AN
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [2:0]  LAST_IDX = 3'(NUM_DIGITS - 1);

    logic [PW-1:0] r_pcnt;
    logic [2:0]    r_idx;
    logic [23:0]   r_value;
    logic [5:0]    r_dp;
    logic          r_blz;
    logic [7:0]    r_sseg;
    logic [5:0]    r_an;

    logic          w_wrap;
    logic          w_frame_start;
    logic [4:0]    w_shift;
    logic [3:0]    w_nibble;
    logic [23:0]   w_higher;
    logic          w_blank;
    logic [6:0]    w_glyph;
    logic [7:0]    w_sseg_nxt;
    logic [5:0]    w_an_nxt;

    assign w_wrap        = (r_pcnt == PW'(PRESCALE - 1));
    assign w_frame_start = (r_pcnt == '0) && (r_idx == '0);

    // Prescaler and digit index; the index only moves on a prescaler wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
            r_idx  <= '0;
        end else if (w_wrap) begin
            r_pcnt <= '0;
            r_idx  <= (r_idx == LAST_IDX) ? '0 : r_idx + 3'd1;
        end else begin
            r_pcnt <= r_pcnt + PW'(1);
        end
    end

    // Frame snapshot, taken in the idx 0 guard cycle so a frame never mixes inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
            r_dp    <= '0;
            r_blz   <= 1'b0;
        end else if (w_frame_start) begin
            r_value <= value;
            r_dp    <= dp;
            r_blz   <= blank_lz;
        end
    end

    // Select the current digit and decide whether it is a suppressed leading zero.
    always_comb begin
        w_shift  = {r_idx, 2'b00};
        w_nibble = r_value[w_shift +: 4];
        w_higher = r_value >> w_shift;
        w_blank  = r_blz && (r_idx != '0) && (w_higher == '0);
    end

    hex_to_sseg u_hex_to_sseg (
        .i_nibble (w_nibble),
        .o_seg    (w_glyph)
    );

    // Next output pattern: dark during the guard cycle or a blanked slot.
    always_comb begin
        w_sseg_nxt = SSEG_BLANK;
        w_an_nxt   = '1;
        if ((r_pcnt != '0) && !w_blank) begin
            w_sseg_nxt = {~r_dp[r_idx], w_glyph};
            w_an_nxt   = ~(6'b000001 << r_idx);
        end
    end

    // Registered outputs, one cycle behind the scan position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sseg <= SSEG_BLANK;
            r_an   <= '1;
        end else begin
            r_sseg <= w_sseg_nxt;
            r_an   <= w_an_nxt;
        end
    end

    assign sseg = r_sseg;
    assign AN   = r_an;

endmodule

// File: tb/tb_sseg_scan.sv
// Self-checking bench for sseg_scan with PRESCALE=4.
module tb_sseg_scan;

    logic        clk;
    logic        rst;
    logic [23:0] value;
    logic [5:0]  dp;
    logic        blank_lz;
    logic [7:0]  sseg;
    logic [5:0]  AN;

    int n_cmp;
    int n_bad;

    // Reference model state: cycles since reset release and the frame snapshot.
    int          m_s;
    logic [23:0] m_val;
    logic [5:0]  m_dp;
    logic        m_blz;

    // Standard active-low seven-segment digits, dp off.
    logic [7:0] ref_glyph [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    sseg_scan #(.PRESCALE(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .dp       (dp),
        .blank_lz (blank_lz),
        .sseg     (sseg),
        .AN       (AN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] exp_sseg, input logic [5:0] exp_an);
        n_cmp++;
        assert ({sseg, AN} === {exp_sseg, exp_an})
        else begin
            n_bad++;
            $error("FAIL %s: observed sseg=%h AN=%h, expected sseg=%h AN=%h",
                   tag, sseg, AN, exp_sseg, exp_an);
        end
    endtask

    // One clock with reset released: advance the model and compare.
    task automatic tick(input string tag);
        int          p;
        int          i;
        logic [23:0] upper;
        logic [7:0]  es;
        logic [5:0]  ea;
        @(posedge clk);
        if (m_s % 24 == 0) begin
            m_val = value;
            m_dp  = dp;
            m_blz = blank_lz;
        end
        p = m_s % 4;
        i = (m_s / 4) % 6;
        m_s++;
        upper = m_val >> (4 * i);
        es = 8'hFF;
        ea = 6'h3F;
        if (p != 0 && !(m_blz && i > 0 && upper == 0)) begin
            es = ref_glyph[upper[3:0]];
            es[7] = ~m_dp[i];
            ea = 6'h3F ^ 6'(1 << i);
        end
        #1;
        check(tag, es, ea);
    endtask

    // One clock with reset held: outputs must stay dark.
    task automatic rst_tick(input string tag);
        @(posedge clk);
        #1;
        check(tag, 8'hFF, 6'h3F);
    endtask

    task automatic release_rst();
        rst = 1'b0;
        m_s = 0;
    endtask

    task automatic frame(input string tag);
        for (int k = 0; k < 24; k++) tick(tag);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        m_s      = 0;
        m_val    = '0;
        m_dp     = '0;
        m_blz    = 1'b0;
        rst      = 1'b1;
        value    = 24'h000123;
        dp       = 6'b000000;
        blank_lz = 1'b0;

        // Reset state held across several edges.
        #2;
        check("reset_async", 8'hFF, 6'h3F);
        for (int k = 0; k < 3; k++) rst_tick("reset_hold");
        release_rst();

        // Plain digits without blanking.
        frame("dec_123");

        // Leading-zero blanking on the same value.
        blank_lz = 1'b1;
        frame("blank_123");

        // All-zero value: only digit 0 with its dp lit.
        value = 24'h000000;
        dp    = 6'b000001;
        frame("zero_dp");

        // Mid-frame change during idx 3 must wait for the next frame.
        value    = 24'h000123;
        dp       = 6'b000000;
        blank_lz = 1'b0;
        for (int k = 0; k < 24; k++) begin
            tick("midframe_old");
            if (k == 13) begin
                value = 24'h654321;
                dp    = 6'b101010;
            end
        end
        frame("midframe_new");

        // Randomized frames, including inputs that change mid-frame.
        for (int f = 0; f < 20; f++) begin
            value    = $urandom & (24'hFFFFFF >> (4 * $urandom_range(0, 6)));
            dp       = 6'($urandom);
            blank_lz = 1'($urandom);
            for (int k = 0; k < 24; k++) begin
                tick("random");
                if (k == $urandom_range(1, 22)) begin
                    value    = 24'($urandom);
                    dp       = 6'($urandom);
                    blank_lz = 1'($urandom);
                end
            end
        end

        // Reset pulse during an active idx 4 cycle aborts the frame.
        value    = 24'hABCDEF;
        dp       = 6'b010000;
        blank_lz = 1'b0;
        while (m_s % 24 != 18) tick("pre_abort");
        #2;
        rst = 1'b1;
        #1;
        check("abort_async", 8'hFF, 6'h3F);
        rst_tick("abort_hold");
        value = 24'h987654;
        release_rst();
        frame("after_abort");
        frame("after_abort2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
